// File: rtl/fp_alu_sched.sv
// fp_alu_sched: round-robin scheduler sharing one combinational fp_alu among NUM_REQ requesters.
// Optional FP_ALU_SCHED_PERF_EN adds saturating perf_ops / perf_wait counters.

// fp_alu: single-precision add/sub/mul with round-to-nearest-even, denormals flushed to zero;
// compare returns B on out and A>B on gt.
module fp_alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  op,
   output logic [31:0] out,
   output logic        gt
);
   logic [31:0] bs, x, y, add_r, mul_r;
   logic        swap, hi, nan;
   logic [23:0] mx, my;
   logic [7:0]  d;
   logic [50:0] ax, ay, sum, norm;
   logic [5:0]  p;
   logic [47:0] prod;

   function automatic logic [31:0] pack(input logic s, input logic [10:0] e, input logic [23:0] m,
                                        input logic g, input logic st);
      logic [24:0] r;
      logic [10:0] ee;
      r  = {1'b0, m} + 25'(g & (st | m[0]));
      ee = e + 11'(r[24]);
      return ($signed(ee) <= 11'sd0) ? {s, 31'd0} :
             ($signed(ee) >= 11'sd255) ? {s, 8'hFF, 23'd0} : {s, ee[7:0], r[22:0]};
   endfunction

   // add/sub: align the smaller magnitude with 26 extension bits; anything further out only sets sticky
   always_comb begin
      bs    = {b[31] ^ op[0], b[30:0]};
      swap  = bs[30:0] > a[30:0];
      x     = swap ? bs : a;
      y     = swap ? a : bs;
      mx    = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
      my    = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
      d     = x[30:23] - y[30:23];
      ax    = {1'b0, mx, 26'd0};
      ay    = (d > 8'd26) ? {50'd0, |my} : ({1'b0, my, 26'd0} >> d);
      sum   = (x[31] == y[31]) ? ax + ay : ax - ay;
      p     = 6'd0;
      for (int i = 0; i < 51; i++) p = sum[i] ? 6'(i) : p;
      norm  = sum << (6'd50 - p);
      add_r = (sum == 51'd0) ? 32'd0 :
              pack(x[31], {3'd0, x[30:23]} + {5'd0, p} - 11'd49, norm[50:27], norm[26], |norm[25:0]);
   end

   // mul: 48-bit mantissa product, leading one at bit 47 or 46
   always_comb begin
      prod  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      hi    = prod[47];
      mul_r = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? {a[31] ^ b[31], 31'd0} :
              pack(a[31] ^ b[31], {3'd0, a[30:23]} + {3'd0, b[30:23]} + {10'd0, hi} - 11'd127,
                   hi ? prod[47:24] : prod[46:23], hi ? prod[23] : prod[22],
                   hi ? |prod[22:0] : |prod[21:0]);
   end

   // ordered compare (NaN and +0/-0 never greater) and result select
   always_comb begin
      nan = (a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0);
      gt  = !nan && (a[30:0] != 31'd0 || b[30:0] != 31'd0) &&
            ((a[31] != b[31]) ? !a[31] : a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]));
      out = op[1] ? (op[0] ? b : mul_r) : add_r;
   end
endmodule

module fp_alu_sched #(
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   input  logic [2*NUM_REQ-1:0]   req_op,
   output logic [NUM_REQ-1:0]     resp_valid,
   input  logic [NUM_REQ-1:0]     resp_ready,
   output logic [31:0]            resp_out,
   output logic                   resp_gt,
   output logic                   busy
`ifdef FP_ALU_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_ops,
   output logic [31:0]            perf_wait
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, nxt;
   logic [IDX_W-1:0] rr_ptr, gnt_idx, win_idx, idx;
   logic             win_vld, accept, done, alu_gt;
   logic [31:0]      opa, opb, alu_out;
   logic [1:0]       opc;

   fp_alu u_alu (.a(opa), .b(opb), .op(opc), .out(alu_out), .gt(alu_gt));

   // first valid requester scanning upward from rr_ptr with wrap; lowest offset wins
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
         if (req_valid[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   assign accept = (state == IDLE) && win_vld;
   assign done   = (state == RESP) && resp_ready[gnt_idx];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // next state: accept -> one EXEC cycle -> hold RESP until the granted requester takes it
   always_comb begin
      nxt = (state == IDLE) ? (win_vld ? EXEC : IDLE) :
            (state == EXEC) ? RESP :
            (state == RESP) ? (done ? IDLE : RESP) : IDLE;
   end

   // handshake outputs, forced low while reset is held
   always_comb begin
      req_ready  = (rst_n && accept) ? NUM_REQ'(1) << win_idx : '0;
      resp_valid = (rst_n && state == RESP) ? NUM_REQ'(1) << gnt_idx : '0;
      busy       = rst_n && (state != IDLE);
   end

   // operand capture on accept, result capture at the end of EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         gnt_idx  <= '0;
         opa      <= '0;
         opb      <= '0;
         opc      <= '0;
         resp_out <= '0;
         resp_gt  <= 1'b0;
      end else begin
         if (accept) begin
            opa     <= req_a[32*win_idx +: 32];
            opb     <= req_b[32*win_idx +: 32];
            opc     <= req_op[2*win_idx +: 2];
            gnt_idx <= win_idx;
            rr_ptr  <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (state == EXEC) begin
            resp_out <= alu_out;
            resp_gt  <= (opc == 2'b11) && alu_gt;
         end
      end
   end

`ifdef FP_ALU_SCHED_PERF_EN
   // saturating counts of completed responses and of cycles with a pending but unaccepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_ops  <= '0;
         perf_wait <= '0;
      end else begin
         if (done && perf_ops != '1) perf_ops <= perf_ops + 32'd1;
         if (|req_valid && !accept && perf_wait != '1) perf_wait <= perf_wait + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fp_alu_sched.sv
// tb_fp_alu_sched: directed and randomized bench for fp_alu_sched against a real-arithmetic reference.
// Honours FP_ALU_SCHED_PERF_EN when defined.
module tb_fp_alu_sched;
   localparam int NQ = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
   logic [127:0]  req_a, req_b;
   logic [7:0]    req_op;
   logic [31:0]   resp_out;
   logic          resp_gt, busy;
`ifdef FP_ALU_SCHED_PERF_EN
   logic [31:0]   perf_ops, perf_wait;
`endif

   int errs = 0, checks = 0, cyc = 0;
   int acc_who[$], acc_cyc[$];

   bit          m_busy = 1'b0;
   int          m_ptr = 0, m_own = 0, m_age = 0, w;
   logic [31:0] m_out = 32'd0;
   logic        m_gt = 1'b0;

   fp_alu_sched #(.NUM_REQ(NQ)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_out(resp_out), .resp_gt(resp_gt), .busy(busy)
`ifdef FP_ALU_SCHED_PERF_EN
      , .perf_ops(perf_ops), .perf_wait(perf_wait)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic real f2r(input logic [31:0] f);
      if (f[30:23] == 8'd0) return 0.0;
      return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
   endfunction

   // nearest-even rounding of an exact-enough double down to single precision
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [24:0] m;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      m = {2'b01, d[51:29]} + 25'(d[28] & ((|d[27:0]) | d[29]));
      e = d[62:52] - 11'd896 + 11'(m[24]);
      return {d[63], e[7:0], m[22:0]};
   endfunction

   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output logic [31:0] o, output logic g);
      real ra, rb;
      ra = f2r(a);
      rb = f2r(b);
      o  = (op == 2'd0) ? r2f(ra + rb) : (op == 2'd1) ? r2f(ra - rb) : (op == 2'd2) ? r2f(ra * rb) : b;
      g  = (op == 2'd3) && (ra > rb);
   endtask

   function automatic int pick(input logic [NQ-1:0] v, input int p);
      for (int k = 0; k < NQ; k++) if (v[(p + k) % NQ]) return (p + k) % NQ;
      return -1;
   endfunction

   // reference: one operation in flight, result visible two cycles after acceptance
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_resp_valid", 32'(resp_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_resp_out", resp_out, 32'd0);
         chk("rst_resp_gt", 32'(resp_gt), 32'd0);
         m_busy = 1'b0;
         m_ptr  = 0;
      end else begin
         w = m_busy ? -1 : pick(req_valid, m_ptr);
         chk("req_ready", 32'(req_ready), (w >= 0) ? 32'd1 << w : 32'd0);
         chk("resp_valid", 32'(resp_valid), (m_busy && m_age >= 2) ? 32'd1 << m_own : 32'd0);
         chk("busy", 32'(busy), 32'(m_busy));
         if (m_busy && m_age >= 2) begin
            chk("resp_out", resp_out, m_out);
            chk("resp_gt", 32'(resp_gt), 32'(m_gt));
         end
         for (int i = 0; i < NQ; i++)
            if (req_valid[i] && req_ready[i]) begin
               acc_who.push_back(i);
               acc_cyc.push_back(cyc);
            end
         if (m_busy) begin
            if (m_age >= 2 && resp_ready[m_own]) m_busy = 1'b0;
            else m_age++;
         end else if (w >= 0) begin
            m_busy = 1'b1;
            m_own  = w;
            m_age  = 1;
            m_ptr  = (w + 1) % NQ;
            model(req_a[32*w +: 32], req_b[32*w +: 32], req_op[2*w +: 2], m_out, m_gt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload(input int i);
      logic [31:0] a, b;
      a = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
      case ($urandom_range(0, 9))
         0: b = a;
         1: b = {~a[31], a[30:0]};
         default: ;
      endcase
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_op[2*i +: 2]  = 2'($urandom);
   endtask

   // present one request and return one cycle after it is accepted (DUT then in EXEC)
   task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      bit got = 1'b0;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_op[2*i +: 2]  = op;
      req_valid[i]      = 1'b1;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         got = req_ready[i];
      end
      chk("send_accept", 32'(got), 32'd1);
      tick();
      req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      req_valid  = '0;
      resp_ready = '1;
      for (int n = 0; n < 20 && busy; n++) tick();
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic rand_cycles(input int n);
      logic [NQ-1:0] hs;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         tick();
         for (int i = 0; i < NQ; i++) begin
            if (hs[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 99) < 60);
               rand_payload(i);
            end else if ($urandom_range(0, 99) < 5) req_valid[i] = 1'b0;
         end
         resp_ready = 4'($urandom);
      end
   endtask

   initial begin
      logic [31:0] mo;
      logic        mg;
      int          rr_exp[5] = '{0, 1, 2, 3, 0};
      rst_n      = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      #1 rst_n   = 1'b0;
      req_valid  = '1;
      // reference model pinned to hand-computed values
      model(32'h3F800000, 32'h40000000, 2'd0, mo, mg);
      chk("model_add", mo, 32'h40400000);
      model(32'h40000000, 32'h40400000, 2'd2, mo, mg);
      chk("model_mul", mo, 32'h40C00000);
      model(32'h40000000, 32'h3F800000, 2'd3, mo, mg);
      chk("model_cmp", {mo[30:0], mg}, {31'h3F800000 >> 0, 1'b1});
      model(32'h3F800000, 32'h33800000, 2'd0, mo, mg);
      chk("model_tie_even", mo, 32'h3F800000);
      model(32'h40400000, 32'h40400000, 2'd1, mo, mg);
      chk("model_cancel", mo, 32'h00000000);
      // reset with all requesters valid, then release
      repeat (3) tick();
      for (int i = 0; i < NQ; i++) rand_payload(i);
      rst_n = 1'b1;
      #1 chk("rst_release_ready", 32'(req_ready), 32'h1);
      // round robin, all valid and responses always taken
      acc_who.delete();
      acc_cyc.delete();
      resp_ready = '1;
      repeat (15) tick();
      drain();
      chk("rr_count", 32'(acc_who.size() >= 5), 32'd1);
      if (acc_who.size() >= 5)
         for (int k = 0; k < 5; k++) begin
            chk("rr_order", 32'(acc_who[k]), 32'(rr_exp[k]));
            if (k > 0) chk("rr_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
         end
      // single add: result two cycles after acceptance
      send(0, 32'h3F800000, 32'h40000000, 2'd0);
      chk("add_exec_rv", 32'(resp_valid), 32'd0);
      tick();
      chk("add_rv", 32'(resp_valid), 32'h1);
      chk("add_out", resp_out, 32'h40400000);
      chk("add_gt", 32'(resp_gt), 32'd0);
      tick();
      chk("add_idle", 32'(busy), 32'd0);
      // backpressure on requester 2; other requesters pending and other resp_ready bits ignored
      resp_ready = '0;
      send(2, 32'h40000000, 32'h40400000, 2'd2);
      tick();
      for (int i = 0; i < NQ; i++) if (i != 2) rand_payload(i);
      req_valid  = 4'b1011;
      resp_ready = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         chk("bp_rv", 32'(resp_valid), 32'h4);
         chk("bp_out", resp_out, 32'h40C00000);
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_ready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 4'b0100;
      chk("bp_hold", 32'(resp_valid), 32'h4);
      tick();
      chk("bp_done", 32'(resp_valid), 32'd0);
      drain();
      // compare both ways, then rounding corner cases
      send(1, 32'h40000000, 32'h3F800000, 2'd3);
      tick();
      chk("cmp_out", resp_out, 32'h3F800000);
      chk("cmp_gt", 32'(resp_gt), 32'd1);
      tick();
      send(1, 32'h3F800000, 32'h40000000, 2'd3);
      tick();
      chk("cmp_swap_out", resp_out, 32'h40000000);
      chk("cmp_swap_gt", 32'(resp_gt), 32'd0);
      tick();
      send(0, 32'h3F800000, 32'h33800000, 2'd0);
      tick();
      chk("rnd_tie", resp_out, 32'h3F800000);
      tick();
      send(0, 32'h3F800000, 32'h33C00000, 2'd0);
      tick();
      chk("rnd_up", resp_out, 32'h3F800001);
      tick();
      // randomized traffic
      rand_cycles(2500);
      drain();
      // reset while in EXEC drops the operation
      resp_ready = '1;
      send(3, 32'h40A00000, 32'h40400000, 2'd1);
      rst_n = 1'b0;
      #1 chk("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      rst_n     = 1'b1;
      req_valid = 4'b1010;
      #1 chk("mid_rst_ready", 32'(req_ready), 32'h2);
      chk("mid_rst_rv", 32'(resp_valid), 32'd0);
`ifdef FP_ALU_SCHED_PERF_EN
      chk("perf_ops_reset", perf_ops, 32'd0);
`endif
      tick();
      drain();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
